// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg -- shared types and constants for the Ethernet transmit path.
//   udp_length_t  : payload byte count
//   s_fifo_cmd_t  : command to the input FIFO (start/clear pulses + length)
//   s_fifo_st_t   : status from the input FIFO
//   fsm_pkt_t     : packet scheduler states
//   len_ok()      : true when a payload length fits the input FIFO
// ----------------------------------------------------------------------------
package eth_pkg;

    localparam int ETH_OT_FIFO        = 4;      // outstanding command slots
    localparam int ETH_INFIFO_KB_SIZE = 1;      // input FIFO size in KiB
    localparam int ETH_TX_TIMEOUT_CYC = 65535;  // streaming watchdog limit
    localparam int ETH_MAX_LEN        = ETH_INFIFO_KB_SIZE * 1024;

    typedef logic [15:0] udp_length_t;

    typedef struct packed {
        logic        start;
        logic        clear;
        udp_length_t length;
    } s_fifo_cmd_t;

    typedef struct packed {
        logic done;
        logic full;
        logic empty;
    } s_fifo_st_t;

    typedef enum logic [1:0] {
        IDLE_PKT_ST      = 2'd0,
        STREAMING_PKT_ST = 2'd1,
        DONE_PKT_ST      = 2'd2
    } fsm_pkt_t;

    // A zero-length packet or one larger than the input FIFO can never complete.
    function automatic logic len_ok(input udp_length_t len);
        return (len != '0) && (int'(len) <= ETH_MAX_LEN);
    endfunction

endpackage

// File: rtl/eth_cmd_queue.sv
// ----------------------------------------------------------------------------
// eth_cmd_queue -- circular queue of pending packet lengths.
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush_i       : empty the queue (dominates push/pop)
//   push_i        : write push_data_i at the tail (caller ensures !full_o)
//   pop_i         : drop the head entry (caller ensures !empty_o)
//   head_o        : current head entry
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ----------------------------------------------------------------------------
module eth_cmd_queue
    import eth_pkg::*;
#(
    parameter int DEPTH = ETH_OT_FIFO
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  udp_length_t              push_data_i,
    input  logic                     pop_i,
    output udp_length_t              head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    udp_length_t mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/eth_tx_sched.sv
// ----------------------------------------------------------------------------
// eth_tx_sched -- queues transmit requests and sequences them into the input
// FIFO one packet at a time, with a streaming watchdog and a global abort.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : send request, accepted when req_ready is also high
//   req_ready    : queue has room and no abort is in progress
//   req_length   : payload byte count of the request
//   req_clear    : abort everything (flush queue, pulse FIFO clear)
//   fifo_cmd_o   : registered start/clear pulses and packet length
//   fifo_st_i    : FIFO status, only .done is consumed
//   busy_o       : packet in flight or commands pending
//   ot_count_o   : number of queued commands (head included until it retires)
//   err_o        : one-cycle pulse on rejected length or watchdog expiry
// ----------------------------------------------------------------------------
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int OT_DEPTH    = ETH_OT_FIFO,
    parameter int TIMEOUT_CYC = ETH_TX_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  udp_length_t               req_length,
    input  logic                      req_clear,
    output s_fifo_cmd_t               fifo_cmd_o,
    input  s_fifo_st_t                fifo_st_i,
    output logic                      busy_o,
    output logic [$clog2(OT_DEPTH):0] ot_count_o,
    output logic                      err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    fsm_pkt_t    state_q, state_d;
    s_fifo_cmd_t cmd_q, cmd_d;
    logic        err_q, err_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic        q_full, q_empty, q_push, q_pop;
    udp_length_t q_head;
    logic        len_good, timeout;

    // Status fields other than .done are deliberately not consumed.
    logic unused_st;
    assign unused_st = fifo_st_i.full ^ fifo_st_i.empty;

    assign req_ready = !q_full && !req_clear;
    assign len_good  = len_ok(req_length);
    // A bad length still handshakes but never reaches the queue.
    assign q_push    = req_valid && req_ready && len_good;
    assign timeout   = (state_q == STREAMING_PKT_ST) && !fifo_st_i.done
                       && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    eth_cmd_queue #(
        .DEPTH(OT_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (req_clear),
        .push_i      (q_push),
        .push_data_i (req_length),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (ot_count_o)
    );

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        cmd_d        = cmd_q;
        cmd_d.start  = 1'b0;
        cmd_d.clear  = 1'b0;
        err_d        = 1'b0;
        q_pop        = 1'b0;

        if (req_clear) begin
            // Abort overrides done, enqueue and timeout in the same cycle.
            state_d     = IDLE_PKT_ST;
            tmo_cnt_d   = '0;
            cmd_d.clear = 1'b1;
        end else begin
            err_d = req_valid && req_ready && !len_good;
            case (state_q)
                IDLE_PKT_ST: begin
                    if (!q_empty) begin
                        state_d      = STREAMING_PKT_ST;
                        cmd_d.start  = 1'b1;
                        cmd_d.length = q_head;
                        tmo_cnt_d    = '0;
                    end
                end
                STREAMING_PKT_ST: begin
                    if (fifo_st_i.done) begin
                        state_d = DONE_PKT_ST;
                    end else if (timeout) begin
                        state_d     = IDLE_PKT_ST;
                        cmd_d.clear = 1'b1;
                        err_d       = 1'b1;
                        q_pop       = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                DONE_PKT_ST: begin
                    state_d = IDLE_PKT_ST;
                    q_pop   = 1'b1;
                end
                default: state_d = IDLE_PKT_ST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE_PKT_ST;
            cmd_q     <= '0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign fifo_cmd_o = cmd_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE_PKT_ST) || !q_empty;

endmodule

// File: tb/tb_eth_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_eth_tx_sched -- directed scenarios followed by random traffic, every
// cycle compared against a transaction-level model of the scheduler.
// ----------------------------------------------------------------------------
module tb_eth_tx_sched;
    import eth_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    udp_length_t req_length;
    logic        req_clear;
    s_fifo_cmd_t fifo_cmd_o;
    s_fifo_st_t  fifo_st_i;
    logic        busy_o;
    logic [$clog2(DEPTH):0] ot_count_o;
    logic        err_o;

    always #5 clk = ~clk;

    eth_tx_sched #(
        .OT_DEPTH    (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_length (req_length),
        .req_clear  (req_clear),
        .fifo_cmd_o (fifo_cmd_o),
        .fifo_st_i  (fifo_st_i),
        .busy_o     (busy_o),
        .ot_count_o (ot_count_o),
        .err_o      (err_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: a list of pending lengths plus the progress of the
    // packet currently handed to the FIFO.
    int m_q[$];
    bit m_sending;     // head handed out, waiting for done
    bit m_finishing;   // done seen, head retires on the next edge
    int m_age;         // cycles the current packet has been outstanding
    int m_len;         // length last announced with start
    bit e_start, e_clear, e_err;

    task automatic model_reset();
        m_q.delete();
        m_sending   = 0;
        m_finishing = 0;
        m_age       = 0;
        m_len       = 0;
        e_start     = 0;
        e_clear     = 0;
        e_err       = 0;
    endtask

    function automatic bit model_ready(input bit clr);
        return (m_q.size() < DEPTH) && !clr;
    endfunction

    task automatic model_edge(input bit v, input int len, input bit clr, input bit done);
        bit accept;
        accept  = v && model_ready(clr);
        e_start = 0;
        e_clear = 0;
        e_err   = 0;
        if (clr) begin
            m_q.delete();
            m_sending   = 0;
            m_finishing = 0;
            e_clear     = 1;
            return;
        end
        if (m_finishing) begin
            void'(m_q.pop_front());
            m_finishing = 0;
        end else if (m_sending) begin
            if (done) begin
                m_sending   = 0;
                m_finishing = 1;
            end else if (m_age + 1 == TMO) begin
                e_clear   = 1;
                e_err     = 1;
                m_sending = 0;
                void'(m_q.pop_front());
            end else begin
                m_age++;
            end
        end else if (m_q.size() > 0) begin
            e_start   = 1;
            m_len     = m_q[0];
            m_sending = 1;
            m_age     = 0;
        end
        if (accept) begin
            if (len >= 1 && len <= ETH_INFIFO_KB_SIZE * 1024) m_q.push_back(len);
            else e_err = 1;
        end
    endtask

    task automatic compare_outputs();
        check("start",  fifo_cmd_o.start,  e_start);
        check("clear",  fifo_cmd_o.clear,  e_clear);
        check("length", fifo_cmd_o.length, m_len);
        check("err",    err_o,             e_err);
        check("busy",   busy_o,            m_sending || m_finishing || (m_q.size() > 0));
        check("count",  ot_count_o,        m_q.size());
    endtask

    // One clock cycle: drive, check ready, clock, advance model, compare.
    task automatic cycle(input bit v, input int len, input bit clr, input bit done);
        req_valid       = v;
        req_length      = udp_length_t'(len);
        req_clear       = clr;
        fifo_st_i.done  = done;
        fifo_st_i.full  = 1'($urandom);
        fifo_st_i.empty = 1'($urandom);
        #1;
        check("req_ready", req_ready, model_ready(clr));
        @(posedge clk);
        model_edge(v, len, clr, done);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0);
    endtask

    function automatic int rand_len();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return $urandom_range(1025, 65535);
            2:       return 1024;
            3:       return 1;
            default: return $urandom_range(1, 1024);
        endcase
    endfunction

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_length = '0;
        req_clear  = 1'b0;
        fifo_st_i  = '0;
        model_reset();
        #1;
        compare_outputs();
        #22 rst_n = 1'b1;

        // Single send of 64 bytes, done after 10 cycles.
        cycle(1, 64, 0, 0);
        idle(10);
        cycle(0, 0, 0, 1);
        idle(3);

        // Backpressure: five back-to-back requests, one done frees a slot.
        for (int i = 0; i < 5; i++) cycle(1, 100 + i, 0, 0);
        repeat (2) cycle(1, 104, 0, 0);
        cycle(1, 104, 0, 1);
        repeat (3) cycle(1, 104, 0, 0);
        repeat (80) cycle(0, 0, 0, ($urandom_range(0, 3) == 0));

        // Bad lengths handshake, pulse err, never start.
        cycle(1, 0, 0, 0);
        idle(1);
        cycle(1, 1025, 0, 0);
        idle(2);

        // Watchdog: two entries, no done ever.
        cycle(1, 200, 0, 0);
        cycle(1, 300, 0, 0);
        idle(40);

        // Clear racing done and a new request.
        for (int i = 0; i < 3; i++) cycle(1, 10 + i, 0, 0);
        idle(2);
        cycle(1, 20, 1, 1);
        idle(3);

        // Reset in the middle of streaming.
        cycle(1, 64, 0, 0);
        idle(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Random traffic.
        repeat (3000) begin
            cycle(($urandom_range(0, 1) == 1), rand_len(),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(TMO + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
